// File: rtl/ebpf_alu32_operand_stage.sv
// ebpf_alu32_operand_stage
// Operand issue stage in front of the 32-bit ALU. S1 holds a decoded ALU32
// instruction while its operands are read from the register file (with
// same-cycle writeback forwarding). S2 is the registered valid/ready operand
// bundle presented to the ALU. Illegal instructions are dropped on their way
// from S1 to S2 and reported with a one-cycle err_illegal pulse.
module ebpf_alu32_operand_stage #(
    parameter int NUM_REGS = 11,
    parameter int RF_AW    = 4,
    parameter int RF_DW    = 64
) (
    input  logic             clk,
    input  logic             rst_n,

    // decoded instruction in
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       in_op,
    input  logic             in_src_is_reg,
    input  logic [RF_AW-1:0] in_dst,
    input  logic [RF_AW-1:0] in_src,
    input  logic [31:0]      in_imm,

    // register file read ports (combinational read)
    output logic [RF_AW-1:0] rf_raddr_a,
    input  logic [RF_DW-1:0] rf_rdata_a,
    output logic [RF_AW-1:0] rf_raddr_b,
    input  logic [RF_DW-1:0] rf_rdata_b,

    // writeback committing this cycle
    input  logic             wb_valid,
    input  logic [RF_AW-1:0] wb_addr,
    input  logic [RF_DW-1:0] wb_data,

    // operand bundle out
    output logic             out_valid,
    input  logic             out_ready,
    output logic [3:0]       out_op,
    output logic [RF_AW-1:0] out_dst,
    output logic [31:0]      out_a,
    output logic [31:0]      out_b,
    output logic             err_illegal
);

    // ALU32 op nibbles that need operand adjustment
    localparam logic [3:0] OP_LSH  = 4'h6;
    localparam logic [3:0] OP_RSH  = 4'h7;
    localparam logic [3:0] OP_NEG  = 4'h8;
    localparam logic [3:0] OP_MOV  = 4'hB;
    localparam logic [3:0] OP_ARSH = 4'hC;
    // highest defined op; D..F are undefined encodings
    localparam logic [3:0] OP_LAST = 4'hC;

    // highest architectural register, which is also the read-only frame pointer
    localparam logic [RF_AW-1:0] RO_REG = RF_AW'(NUM_REGS - 1);

    // ------------------------------------------------------------------
    // S1: captured instruction
    // ------------------------------------------------------------------
    logic             s1_valid_reg;
    logic [3:0]       s1_op_reg;
    logic             s1_src_is_reg_reg;
    logic [RF_AW-1:0] s1_dst_reg;
    logic [RF_AW-1:0] s1_src_reg;
    logic [31:0]      s1_imm_reg;

    // ------------------------------------------------------------------
    // S2: output bundle
    // ------------------------------------------------------------------
    logic             s2_valid_reg;
    logic [3:0]       s2_op_reg;
    logic [RF_AW-1:0] s2_dst_reg;
    logic [31:0]      s2_a_reg;
    logic [31:0]      s2_b_reg;
    logic             err_illegal_reg;

    // ------------------------------------------------------------------
    // handshake
    // ------------------------------------------------------------------
    logic s2_adv;
    logic s1_load;
    logic s1_move;
    logic s1_illegal;
    logic s2_load;

    assign s2_adv   = !s2_valid_reg || out_ready;
    assign in_ready = !s1_valid_reg || s2_adv;
    assign s1_load  = in_valid && in_ready;
    assign s1_move  = s1_valid_reg && s2_adv;
    assign s2_load  = s1_move && !s1_illegal;

    // Legality is judged on the captured fields as the instruction leaves S1.
    // Writing r10 (or anything above it) is illegal; reading r10 is fine.
    always_comb begin
        s1_illegal = 1'b0;
        if (s1_op_reg > OP_LAST)
            s1_illegal = 1'b1;
        if (s1_dst_reg >= RO_REG)
            s1_illegal = 1'b1;
        if (s1_src_is_reg_reg && (s1_src_reg > RO_REG))
            s1_illegal = 1'b1;
    end

    // ------------------------------------------------------------------
    // register reads and writeback forwarding
    // ------------------------------------------------------------------
    // Addresses are parked at r0 when S1 is empty so the RF sees a quiet bus.
    assign rf_raddr_a = s1_valid_reg ? s1_dst_reg : '0;
    assign rf_raddr_b = s1_valid_reg ? s1_src_reg : '0;

    logic [RF_AW-1:0] rd_addr [2];
    logic [31:0]      rd_low  [2];
    logic [31:0]      fwd_val [2];

    assign rd_addr[0] = s1_dst_reg;
    assign rd_addr[1] = s1_src_reg;
    assign rd_low[0]  = rf_rdata_a[31:0];
    assign rd_low[1]  = rf_rdata_b[31:0];

    // Writeback committing this cycle wins over the (still stale) RF data.
    // Re-evaluated every cycle, so a writeback landing while S1 is stalled
    // is picked up before the instruction moves on.
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_fwd
            assign fwd_val[gi] = (wb_valid && (wb_addr == rd_addr[gi])) ?
                                 wb_data[31:0] : rd_low[gi];
        end
    endgenerate

    // ALU32 only consumes the low words; the upper halves are intentionally dropped.
    logic unused_hi;
    assign unused_hi = ^{wb_data[RF_DW-1:32], rf_rdata_a[RF_DW-1:32], rf_rdata_b[RF_DW-1:32]};

    // ------------------------------------------------------------------
    // ALU32 operand rules
    // ------------------------------------------------------------------
    logic [31:0] op_a;
    logic [31:0] op_b;

    // Select b source, then apply shift masking / NEG / MOV operand rules.
    always_comb begin
        op_a = fwd_val[0];
        op_b = s1_src_is_reg_reg ? fwd_val[1] : s1_imm_reg;
        case (s1_op_reg)
            OP_LSH, OP_RSH, OP_ARSH: op_b = op_b & 32'h0000_001F;
            OP_NEG:                  op_b = 32'h0;
            OP_MOV:                  op_a = 32'h0;
            default:                 ;
        endcase
    end

    // ------------------------------------------------------------------
    // sequential state
    // ------------------------------------------------------------------
    // S1 reloads on accept (even while draining in the same edge), else empties on move.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_reg      <= 1'b0;
            s1_op_reg         <= 4'h0;
            s1_src_is_reg_reg <= 1'b0;
            s1_dst_reg        <= '0;
            s1_src_reg        <= '0;
            s1_imm_reg        <= 32'h0;
        end else if (s1_load) begin
            s1_valid_reg      <= 1'b1;
            s1_op_reg         <= in_op;
            s1_src_is_reg_reg <= in_src_is_reg;
            s1_dst_reg        <= in_dst;
            s1_src_reg        <= in_src;
            s1_imm_reg        <= in_imm;
        end else if (s1_move) begin
            s1_valid_reg      <= 1'b0;
        end
    end

    // S2 updates whenever it may advance; illegal or absent S1 leaves it empty,
    // and its payload only changes when a legal bundle lands (held otherwise).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_valid_reg <= 1'b0;
            s2_op_reg    <= 4'h0;
            s2_dst_reg   <= '0;
            s2_a_reg     <= 32'h0;
            s2_b_reg     <= 32'h0;
        end else if (s2_adv) begin
            s2_valid_reg <= s2_load;
            if (s2_load) begin
                s2_op_reg  <= s1_op_reg;
                s2_dst_reg <= s1_dst_reg;
                s2_a_reg   <= op_a;
                s2_b_reg   <= op_b;
            end
        end
    end

    // Error pulse lands in the slot the dropped instruction would have occupied.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            err_illegal_reg <= 1'b0;
        else
            err_illegal_reg <= s1_move && s1_illegal;
    end

    assign out_valid   = s2_valid_reg;
    assign out_op      = s2_op_reg;
    assign out_dst     = s2_dst_reg;
    assign out_a       = s2_a_reg;
    assign out_b       = s2_b_reg;
    assign err_illegal = err_illegal_reg;

endmodule

// File: tb/tb_ebpf_alu32_operand_stage.sv
// Bench for ebpf_alu32_operand_stage: directed scenarios with literal
// expectations plus a randomized phase, all checked every cycle against a
// transaction-level model (in-order queue, register snapshots, slot timing).
module tb_ebpf_alu32_operand_stage;

    localparam int RF_AW = 4;
    localparam int RF_DW = 64;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [3:0]       in_op = 4'h0;
    logic             in_src_is_reg = 1'b0;
    logic [RF_AW-1:0] in_dst = '0;
    logic [RF_AW-1:0] in_src = '0;
    logic [31:0]      in_imm = 32'h0;
    logic [RF_AW-1:0] rf_raddr_a;
    logic [RF_DW-1:0] rf_rdata_a;
    logic [RF_AW-1:0] rf_raddr_b;
    logic [RF_DW-1:0] rf_rdata_b;
    logic             wb_valid = 1'b0;
    logic [RF_AW-1:0] wb_addr = '0;
    logic [RF_DW-1:0] wb_data = '0;
    logic             out_valid;
    logic             out_ready = 1'b1;
    logic [3:0]       out_op;
    logic [RF_AW-1:0] out_dst;
    logic [31:0]      out_a;
    logic [31:0]      out_b;
    logic             err_illegal;

    always #5 clk = ~clk;

    ebpf_alu32_operand_stage #(.NUM_REGS(11), .RF_AW(RF_AW), .RF_DW(RF_DW)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
        .in_src_is_reg(in_src_is_reg), .in_dst(in_dst), .in_src(in_src), .in_imm(in_imm),
        .rf_raddr_a(rf_raddr_a), .rf_rdata_a(rf_rdata_a),
        .rf_raddr_b(rf_raddr_b), .rf_rdata_b(rf_rdata_b),
        .wb_valid(wb_valid), .wb_addr(wb_addr), .wb_data(wb_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_op(out_op), .out_dst(out_dst),
        .out_a(out_a), .out_b(out_b), .err_illegal(err_illegal)
    );

    // register file model: combinational read, write on committed writeback
    logic [RF_DW-1:0] rf [16];
    assign rf_rdata_a = rf[rf_raddr_a];
    assign rf_rdata_b = rf[rf_raddr_b];

    always @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < 16; i++) rf[i] <= '0;
        end else if (wb_valid) begin
            rf[wb_addr] <= wb_data;
        end
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    // ------------------------------------------------------------------
    // reference model
    // ------------------------------------------------------------------
    typedef struct {
        int          a;
        logic [3:0]  op;
        logic        sr;
        logic [3:0]  dst;
        logic [3:0]  src;
        logic [31:0] imm;
        bit          legal;
    } ins_t;

    typedef struct {
        int          c;
        logic [3:0]  op;
        logic [3:0]  dst;
        logic [31:0] a;
        logic [31:0] b;
    } fire_t;

    ins_t        q[$];
    ins_t        h;
    fire_t       log_q[$];
    fire_t       f;
    bit          cur_v = 0;
    logic [3:0]  cur_op, cur_dst;
    logic [31:0] cur_a, cur_b;
    int          err_exp_cyc = -100;
    int          err_seen = 0;
    logic [63:0] snap [16];
    bit          exp_rdy;

    function automatic bit is_legal(input logic [3:0] op, input logic sr,
                                    input logic [3:0] d, input logic [3:0] s);
        return (op <= 4'd12) && (d <= 4'd9) && (!sr || s <= 4'd10);
    endfunction

    // Each cycle: present the next queued instruction when its slot opens,
    // compare all outputs, retire on handshake, predict in_ready, record accepts.
    initial begin
        for (int i = 0; i < 16; i++) snap[i] = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                q.delete();
                cur_v = 0;
                err_exp_cyc = -100;
                chk("reset_out_valid", out_valid, 0);
                chk("reset_err_illegal", err_illegal, 0);
            end else begin
                if (!cur_v && q.size() > 0 && cyc >= q[0].a + 2) begin
                    h = q.pop_front();
                    if (h.legal) begin
                        cur_v   = 1;
                        cur_op  = h.op;
                        cur_dst = h.dst;
                        cur_a   = (h.op == 4'd11) ? 32'd0 : snap[h.dst][31:0];
                        cur_b   = h.sr ? snap[h.src][31:0] : h.imm;
                        if (h.op == 4'd6 || h.op == 4'd7 || h.op == 4'd12) cur_b = cur_b % 32;
                        if (h.op == 4'd8) cur_b = 0;
                    end else begin
                        err_exp_cyc = cyc;
                    end
                end
                chk("out_valid", out_valid, cur_v);
                chk("err_illegal", err_illegal, err_exp_cyc == cyc);
                if (err_illegal) err_seen++;
                if (cur_v && out_valid) begin
                    chk("out_op", out_op, cur_op);
                    chk("out_dst", out_dst, cur_dst);
                    chk("out_a", out_a, cur_a);
                    chk("out_b", out_b, cur_b);
                end
                if (cur_v && out_ready) begin
                    f.c = cyc; f.op = out_op; f.dst = out_dst; f.a = out_a; f.b = out_b;
                    log_q.push_back(f);
                    cur_v = 0;
                end
                exp_rdy = (q.size() == 0) || (!cur_v && (cyc + 1 >= q[0].a + 2));
                chk("in_ready", in_ready, exp_rdy);
                if (in_valid && in_ready) begin
                    h.a = cyc; h.op = in_op; h.sr = in_src_is_reg; h.dst = in_dst;
                    h.src = in_src; h.imm = in_imm;
                    h.legal = is_legal(in_op, in_src_is_reg, in_dst, in_src);
                    q.push_back(h);
                end
            end
            for (int i = 0; i < 16; i++) snap[i] = rf[i];
            if (wb_valid) snap[wb_addr] = wb_data;
        end
    end

    // ------------------------------------------------------------------
    // stimulus helpers (inputs change #1 after the rising edge)
    // ------------------------------------------------------------------
    task automatic issue(input logic [3:0] op, input logic sr, input logic [3:0] d,
                         input logic [3:0] s, input logic [31:0] imm, output int acc);
        in_op = op; in_src_is_reg = sr; in_dst = d; in_src = s; in_imm = imm;
        in_valid = 1'b1;
        acc = -1;
        for (int k = 0; k < 50 && acc < 0; k++) begin
            @(negedge clk);
            if (in_ready) acc = cyc;
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        if (acc < 0) begin
            n_cmp++; n_bad++;
            $display("FAIL issue_timeout: got no accept expected accept within 50 cycles");
        end
    endtask

    task automatic rf_write(input logic [3:0] addr, input logic [63:0] data);
        wb_valid = 1'b1; wb_addr = addr; wb_data = data;
        @(posedge clk); #1;
        wb_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    int acc, acc0, e0;

    initial begin
        // power-on reset
        idle(3);
        @(negedge clk); #1 rst_n = 1'b1;
        @(negedge clk);
        chk("rst_out_a", out_a, 0);
        chk("rst_out_b", out_b, 0);
        chk("rst_out_op", out_op, 0);
        chk("rst_out_dst", out_dst, 0);
        chk("rst_in_ready", in_ready, 1);
        @(posedge clk); #1;

        // reset with both stages full
        out_ready = 1'b0;
        issue(4'd0, 1'b0, 4'd1, 4'd0, 32'h1, acc);
        issue(4'd1, 1'b0, 4'd2, 4'd0, 32'h2, acc);
        #1 rst_n = 1'b0;
        #1;
        chk("midrst_out_valid", out_valid, 0);
        chk("midrst_err", err_illegal, 0);
        repeat (2) @(negedge clk);
        #1 rst_n = 1'b1;
        out_ready = 1'b1;
        log_q.delete();
        @(posedge clk); #1;
        rf_write(4'd1, 64'h0000_0000_8000_0000);
        chk("midrst_no_output", log_q.size(), 0);
        issue(4'd12, 1'b0, 4'd1, 4'd0, 32'h4, acc);
        idle(3);
        chk("arsh_count", log_q.size(), 1);
        if (log_q.size() >= 1) begin
            chk("arsh_latency", log_q[0].c, acc + 2);
            chk("arsh_a", log_q[0].a, 32'h8000_0000);
            chk("arsh_b", log_q[0].b, 32'h4);
        end

        // shift masking
        rf_write(4'd2, 64'h25);
        log_q.delete();
        issue(4'd7, 1'b1, 4'd1, 4'd2, 32'h0, acc);
        issue(4'd12, 1'b0, 4'd1, 4'd0, 32'hFFFF_FFE1, acc);
        idle(4);
        chk("mask_count", log_q.size(), 2);
        if (log_q.size() >= 2) begin
            chk("rsh_b", log_q[0].b, 32'h5);
            chk("rsh_a", log_q[0].a, 32'h8000_0000);
            chk("arsh_imm_b", log_q[1].b, 32'h1);
        end

        // forwarding in the S1 cycle, both operands on r3
        rf_write(4'd3, 64'h11);
        log_q.delete();
        issue(4'd0, 1'b1, 4'd3, 4'd3, 32'h0, acc);
        wb_valid = 1'b1; wb_addr = 4'd3; wb_data = 64'hABCD_0000_1234_5678;
        @(posedge clk); #1;
        wb_valid = 1'b0;
        idle(2);
        chk("fwd_count", log_q.size(), 1);
        if (log_q.size() >= 1) begin
            chk("fwd_a", log_q[0].a, 32'h1234_5678);
            chk("fwd_b", log_q[0].b, 32'h1234_5678);
        end

        // backpressure: 2 accepted, third held off for 5 cycles
        out_ready = 1'b0;
        log_q.delete();
        issue(4'd0, 1'b0, 4'd1, 4'd0, 32'h10, acc);
        issue(4'd1, 1'b0, 4'd2, 4'd0, 32'h20, acc);
        in_op = 4'd4; in_src_is_reg = 1'b0; in_dst = 4'd4; in_src = 4'd0; in_imm = 32'h30;
        in_valid = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("bp_in_ready", in_ready, 0);
            chk("bp_out_valid", out_valid, 1);
            chk("bp_hold_a", out_a, 32'h8000_0000);
            chk("bp_hold_b", out_b, 32'h10);
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        @(negedge clk);
        chk("bp_release_ready", in_ready, 1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        idle(4);
        chk("bp_count", log_q.size(), 3);
        if (log_q.size() >= 3) begin
            chk("bp_order0", log_q[0].op, 4'd0);
            chk("bp_order1", log_q[1].op, 4'd1);
            chk("bp_order2", log_q[2].op, 4'd4);
            chk("bp_b1", log_q[1].b, 32'h20);
            chk("bp_a2", log_q[2].a, 32'h0);
            chk("bp_consec", log_q[2].c - log_q[0].c, 2);
        end

        // illegal instructions, then a legal XOR
        log_q.delete();
        e0 = err_seen;
        issue(4'hE, 1'b0, 4'd1, 4'd0, 32'h0, acc);
        issue(4'd0, 1'b0, 4'd10, 4'd0, 32'h1, acc);
        issue(4'd0, 1'b1, 4'd1, 4'd12, 32'h0, acc);
        issue(4'd10, 1'b0, 4'd1, 4'd0, 32'hFF, acc);
        idle(4);
        chk("illegal_pulses", err_seen - e0, 3);
        chk("illegal_outputs", log_q.size(), 1);
        if (log_q.size() >= 1) begin
            chk("xor_latency", log_q[0].c, acc + 2);
            chk("xor_b", log_q[0].b, 32'hFF);
            chk("xor_op", log_q[0].op, 4'd10);
        end

        // throughput: 16 back-to-back legal instructions
        log_q.delete();
        acc0 = -1;
        for (int k = 0; k < 16; k++) begin
            issue(4'($urandom_range(0, 12)), 1'($urandom_range(0, 1)),
                  4'($urandom_range(0, 9)), 4'($urandom_range(0, 10)), $urandom, acc);
            if (k == 0) acc0 = acc;
        end
        idle(4);
        chk("tput_count", log_q.size(), 16);
        if (log_q.size() >= 16) begin
            chk("tput_first", log_q[0].c, acc0 + 2);
            chk("tput_span", log_q[15].c - log_q[0].c, 15);
        end

        // randomized traffic, checked by the model every cycle
        for (int k = 0; k < 1500; k++) begin
            in_valid      = ($urandom_range(0, 3) != 0);
            in_op         = 4'($urandom_range(0, 15));
            in_src_is_reg = 1'($urandom_range(0, 1));
            in_dst        = 4'($urandom_range(0, 11));
            in_src        = 4'($urandom_range(0, 11));
            in_imm        = $urandom;
            out_ready     = ($urandom_range(0, 3) != 0);
            wb_valid      = ($urandom_range(0, 2) == 0);
            wb_addr       = 4'($urandom_range(0, 15));
            wb_data       = {$urandom, $urandom};
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        wb_valid = 1'b0;
        out_ready = 1'b1;
        idle(10);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
